// File: rtl/pacman_mover.sv
// pacman_mover: owns Pac-Man's tile position and drives it to the sprite renderer.
//
// Each movement step the mover tries the tile in the latched
// player-requested direction. If that tile is a wall, it tries the tile
// straight ahead in the current facing. If both are blocked, it stays put.
// Each try is one query to the external maze wall map.
//
// Ports
//   clk                 system clock
//   reset_n             synchronous active-low reset
//   gameover            freezes motion, key latch and the step divider while high
//   key_up/down/left/right
//                       level-sensitive direction requests (up > down > left > right)
//   wall_req            one-cycle wall-map query strobe
//   wall_x, wall_y      tile being queried (hold last value between queries)
//   wall_in             wall bit for the query, valid the cycle after wall_req
//   pac_x, pac_y        current tile (to renderer)
//   pac_dir             facing: 00 right, 01 left, 10 up, 11 down
//   step                one-cycle pulse in the first cycle a new position is visible
//
// Build option
//   TUNNEL_WRAP_EN      when defined, moves off a maze edge wrap to the
//                       opposite edge and are queried normally. When
//                       undefined, the maze edges are hard walls and are
//                       never queried.
module pacman_mover #(
    parameter int unsigned COLS     = 25,
    parameter int unsigned ROWS     = 22,
    parameter int unsigned START_X  = 12,
    parameter int unsigned START_Y  = 16,
    parameter int unsigned MOVE_DIV = 5000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       gameover,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic       wall_req,
    output logic [4:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_in,
    output logic [4:0] pac_x,
    output logic [4:0] pac_y,
    output logic [1:0] pac_dir,
    output logic       step
);

    localparam int unsigned CNT_W = $clog2(MOVE_DIV);

    localparam logic [4:0] X_LAST  = 5'(COLS - 1);
    localparam logic [4:0] Y_LAST  = 5'(ROWS - 1);
    localparam logic [4:0] X_START = 5'(START_X);
    localparam logic [4:0] Y_START = 5'(START_Y);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        Q_DES,
        W_DES,
        Q_CUR,
        W_CUR
    } state_t;

    // Candidate tile; ok=0 means it lies off the maze edge.
    typedef struct packed {
        logic       ok;
        logic [4:0] x;
        logic [4:0] y;
    } tile_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         desired_dir;

    logic               tick;
    logic               key_any;
    logic [1:0]         key_dir;
    tile_t              des_tile;
    tile_t              cur_tile;

    // One coordinate step along an axis; returns {in_grid, new_value}.
    function automatic logic [5:0] step_axis(input logic [4:0] v,
                                             input logic       inc,
                                             input logic [4:0] last);
        logic [5:0] r;
        if (inc) begin
            if (v == last) begin
`ifdef TUNNEL_WRAP_EN
                r = {1'b1, 5'd0};
`else
                r = {1'b0, v};
`endif
            end else begin
                r = {1'b1, v + 5'd1};
            end
        end else begin
            if (v == 5'd0) begin
`ifdef TUNNEL_WRAP_EN
                r = {1'b1, last};
`else
                r = {1'b0, v};
`endif
            end else begin
                r = {1'b1, v - 5'd1};
            end
        end
        return r;
    endfunction

    // Adjacent tile of (x,y) in direction d.
    function automatic tile_t neighbour(input logic [4:0] x,
                                        input logic [4:0] y,
                                        input logic [1:0] d);
        tile_t      t;
        logic [5:0] s;
        t.ok = 1'b1;
        t.x  = x;
        t.y  = y;
        case (d)
            DIR_RIGHT: begin
                s    = step_axis(x, 1'b1, X_LAST);
                t.ok = s[5];
                t.x  = s[4:0];
            end
            DIR_LEFT: begin
                s    = step_axis(x, 1'b0, X_LAST);
                t.ok = s[5];
                t.x  = s[4:0];
            end
            DIR_UP: begin
                s    = step_axis(y, 1'b0, Y_LAST);
                t.ok = s[5];
                t.y  = s[4:0];
            end
            default: begin
                s    = step_axis(y, 1'b1, Y_LAST);
                t.ok = s[5];
                t.y  = s[4:0];
            end
        endcase
        return t;
    endfunction

    // Movement step strobe from the divider.
    assign tick = (cnt == CNT_W'(MOVE_DIV - 1));

    // Highest-priority pressed key.
    assign key_any = key_up | key_down | key_left | key_right;

    always_comb begin
        key_dir = DIR_RIGHT;
        if (key_up) begin
            key_dir = DIR_UP;
        end else if (key_down) begin
            key_dir = DIR_DOWN;
        end else if (key_left) begin
            key_dir = DIR_LEFT;
        end
    end

    // Candidate tiles for the requested turn and for going straight.
    assign des_tile = neighbour(pac_x, pac_y, desired_dir);
    assign cur_tile = neighbour(pac_x, pac_y, pac_dir);

    // Key latch, step divider and lookup FSM. wall_x/wall_y double as the
    // registered target tile, so a granted move simply copies them into pac.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            desired_dir <= DIR_LEFT;
            pac_x       <= X_START;
            pac_y       <= Y_START;
            pac_dir     <= DIR_LEFT;
            wall_req    <= 1'b0;
            wall_x      <= 5'd0;
            wall_y      <= 5'd0;
            step        <= 1'b0;
        end else begin
            wall_req <= 1'b0;
            step     <= 1'b0;

            if (!gameover && key_any) begin
                desired_dir <= key_dir;
            end

            if (gameover || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (tick && !gameover) begin
                        if (des_tile.ok) begin
                            wall_req <= 1'b1;
                            wall_x   <= des_tile.x;
                            wall_y   <= des_tile.y;
                            state    <= Q_DES;
                        end else if ((desired_dir != pac_dir) && cur_tile.ok) begin
                            // Requested turn leaves the maze: behave as if
                            // it were a wall and try straight ahead at once.
                            wall_req <= 1'b1;
                            wall_x   <= cur_tile.x;
                            wall_y   <= cur_tile.y;
                            state    <= Q_CUR;
                        end
                    end
                end

                Q_DES: begin
                    state <= gameover ? IDLE : W_DES;
                end

                W_DES: begin
                    if (gameover) begin
                        state <= IDLE;
                    end else if (!wall_in) begin
                        pac_x   <= wall_x;
                        pac_y   <= wall_y;
                        pac_dir <= desired_dir;
                        step    <= 1'b1;
                        state   <= IDLE;
                    end else if ((desired_dir == pac_dir) || !cur_tile.ok) begin
                        state <= IDLE;
                    end else begin
                        wall_req <= 1'b1;
                        wall_x   <= cur_tile.x;
                        wall_y   <= cur_tile.y;
                        state    <= Q_CUR;
                    end
                end

                Q_CUR: begin
                    state <= gameover ? IDLE : W_CUR;
                end

                W_CUR: begin
                    if (!gameover && !wall_in) begin
                        pac_x <= wall_x;
                        pac_y <= wall_y;
                        step  <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: self-checking bench for pacman_mover (MOVE_DIV = 8).
// A cycle-level reference predicts each movement step as a small plan of
// timed events (queries, move) built from the maze rules; a table of
// directed moves and a randomized phase exercise it.
module tb_pacman_mover;

    localparam int COLS = 25;
    localparam int ROWS = 22;
    localparam int MD   = 8;
`ifdef TUNNEL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, gameover;
    logic       key_up, key_down, key_left, key_right;
    logic       wall_req, wall_in, step;
    logic [4:0] wall_x, wall_y, pac_x, pac_y;
    logic [1:0] pac_dir;

    pacman_mover #(
        .COLS(COLS), .ROWS(ROWS), .START_X(12), .START_Y(16), .MOVE_DIV(MD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .gameover(gameover),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y), .wall_in(wall_in),
        .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir), .step(step)
    );

    always #5 clk = ~clk;

    // Wall map indexed [x][y]; answer is valid only the cycle after a query.
    bit wall_map [32][32];

    always @(posedge clk) begin
        if (wall_req === 1'b1) wall_in <= wall_map[wall_x][wall_y];
        else                   wall_in <= 1'($urandom_range(0, 1));
    end

    int checks = 0;
    int errors = 0;
    int ent_q, ent_s;

    // Reference state
    int m_x, m_y, m_dir, m_des, m_cnt;
    int cyc = 0;
    int idle_cyc = 0;
    int qa_c, qa_x, qa_y, qb_c, qb_x, qb_y, mv_c, mv_x, mv_y, mv_d;
    int e_step, e_req, e_wx, e_wy;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dxf(input int d);
        if (d == 0) return 1;
        if (d == 1) return -1;
        return 0;
    endfunction

    function automatic int dyf(input int d);
        if (d == 2) return -1;
        if (d == 3) return 1;
        return 0;
    endfunction

    task automatic nbr(input int x, input int y, input int d,
                       output int nx, output int ny, output bit ok);
        nx = x + dxf(d);
        ny = y + dyf(d);
        ok = 1'b1;
        if (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) begin
            if (WRAP) begin
                nx = (nx + COLS) % COLS;
                ny = (ny + ROWS) % ROWS;
            end else begin
                ok = 1'b0;
            end
        end
    endtask

    // Schedule the queries and move that a step starting at cycle t produces.
    task automatic plan(input int t);
        int ax, ay, bx, by;
        bit aok, bok;
        nbr(m_x, m_y, m_des, ax, ay, aok);
        nbr(m_x, m_y, m_dir, bx, by, bok);
        if (aok) begin
            qa_c = t + 1; qa_x = ax; qa_y = ay;
            if (!wall_map[ax][ay]) begin
                mv_c = t + 3; mv_x = ax; mv_y = ay; mv_d = m_des; idle_cyc = t + 3;
            end else if (m_des == m_dir || !bok) begin
                idle_cyc = t + 3;
            end else begin
                qb_c = t + 3; qb_x = bx; qb_y = by; idle_cyc = t + 5;
                if (!wall_map[bx][by]) begin
                    mv_c = t + 5; mv_x = bx; mv_y = by; mv_d = m_dir;
                end
            end
        end else if (m_des != m_dir && bok) begin
            qb_c = t + 1; qb_x = bx; qb_y = by; idle_cyc = t + 3;
            if (!wall_map[bx][by]) begin
                mv_c = t + 3; mv_x = bx; mv_y = by; mv_d = m_dir;
            end
        end else begin
            idle_cyc = t + 1;
        end
    endtask

    // Advance the reference by the current cycle's inputs.
    task automatic model_update();
        int c;
        c = cyc;
        if (reset_n !== 1'b1) begin
            m_x = 12; m_y = 16; m_dir = 1; m_des = 1; m_cnt = 0;
            idle_cyc = c + 1;
            qa_c = -1; qb_c = -1; mv_c = -1;
            e_wx = 0; e_wy = 0;
        end else begin
            if (c < idle_cyc && gameover) begin
                if (qa_c > c) qa_c = -1;
                if (qb_c > c) qb_c = -1;
                if (mv_c > c) mv_c = -1;
                idle_cyc = c + 1;
            end else if (c >= idle_cyc && m_cnt == MD - 1 && !gameover) begin
                plan(c);
            end
            if (!gameover) begin
                if (key_up)         m_des = 2;
                else if (key_down)  m_des = 3;
                else if (key_left)  m_des = 1;
                else if (key_right) m_des = 0;
            end
            m_cnt = gameover ? 0 : (m_cnt + 1) % MD;
        end
        e_step = 0;
        e_req  = 0;
        if (mv_c == c + 1) begin
            m_x = mv_x; m_y = mv_y; m_dir = mv_d; e_step = 1;
        end
        if (qa_c == c + 1) begin e_req = 1; e_wx = qa_x; e_wy = qa_y; end
        if (qb_c == c + 1) begin e_req = 1; e_wx = qb_x; e_wy = qb_y; end
        cyc++;
    endtask

    // One clock: predict, let the edge happen, compare on the falling edge.
    task automatic cycle();
        model_update();
        @(negedge clk);
        check("pac_x", 32'(pac_x), m_x);
        check("pac_y", 32'(pac_y), m_y);
        check("pac_dir", 32'(pac_dir), m_dir);
        check("step", 32'(step), e_step);
        check("wall_req", 32'(wall_req), e_req);
        check("wall_x", 32'(wall_x), e_wx);
        check("wall_y", 32'(wall_y), e_wy);
        if (wall_req === 1'b1) ent_q++;
        if (step === 1'b1) ent_s++;
    endtask

    task automatic wait_phase();
        int n;
        n = 0;
        while (!(m_cnt == 5 && cyc >= idle_cyc) && n < 64) begin
            cycle();
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL phase_timeout: got %0d cycles expected under 64", n);
        end
    endtask

    task automatic clear_map();
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                wall_map[x][y] = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [3:0] keys;   // {up, down, left, right}
        int         wx0, wy0, wx1, wy1;
        int         ticks;
        int         ex, ey, edir, eq, es;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int lat, qx, qy;

        vecs[0]  = '{"hold_left",        4'b0000, -1, -1, -1, -1, 1,  11, 16, 1, 1, 1};
        vecs[1]  = '{"up_fallback",      4'b1000, 11, 15, -1, -1, 1,  10, 16, 1, 2, 1};
        vecs[2]  = '{"both_blocked",     4'b0000, 10, 15,  9, 16, 1,  10, 16, 1, 2, 0};
        vecs[3]  = '{"up_right_prio",    4'b1001, -1, -1, -1, -1, 1,  10, 15, 2, 1, 1};
        vecs[4]  = '{"down_fallback",    4'b0100, 10, 16, -1, -1, 1,  10, 14, 2, 2, 1};
        vecs[5]  = '{"right_two",        4'b0001, -1, -1, -1, -1, 2,  12, 14, 0, 2, 2};
        vecs[6]  = '{"left_fallback",    4'b0010, 11, 14, -1, -1, 1,  13, 14, 0, 2, 1};
        vecs[7]  = '{"straight_blocked", 4'b0001, 14, 14, -1, -1, 1,  13, 14, 0, 1, 0};
        vecs[8]  = '{"up_four",          4'b1000, -1, -1, -1, -1, 4,  13, 10, 2, 4, 4};
        vecs[9]  = '{"left_to_edge",     4'b0010, -1, -1, -1, -1, 13,  0, 10, 1, 13, 13};
        if (WRAP) begin
            vecs[10] = '{"edge_left",     4'b0000, -1, -1, -1, -1, 1, 24, 10, 1, 1, 1};
            vecs[11] = '{"edge_down",     4'b0100, -1, -1, -1, -1, 1, 24, 11, 3, 1, 1};
            vecs[12] = '{"edge_left2",    4'b0010, -1, -1, -1, -1, 1, 23, 11, 1, 1, 1};
        end else begin
            vecs[10] = '{"edge_left",     4'b0000, -1, -1, -1, -1, 1,  0, 10, 1, 0, 0};
            vecs[11] = '{"edge_down",     4'b0100, -1, -1, -1, -1, 1,  0, 11, 3, 1, 1};
            vecs[12] = '{"edge_left2",    4'b0010, -1, -1, -1, -1, 1,  0, 12, 3, 1, 1};
        end

        reset_n = 1'b0; gameover = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        clear_map();

        // Reset, then explicit reset-state checks.
        cycle();
        cycle();
        check("rst_pac_x", 32'(pac_x), 12);
        check("rst_pac_y", 32'(pac_y), 16);
        check("rst_pac_dir", 32'(pac_dir), 1);
        check("rst_wall_req", 32'(wall_req), 0);
        check("rst_step", 32'(step), 0);
        reset_n = 1'b1;
        wait_phase();

        // Directed moves from the table.
        for (int i = 0; i < 13; i++) begin
            clear_map();
            if (vecs[i].wx0 >= 0) wall_map[vecs[i].wx0][vecs[i].wy0] = 1'b1;
            if (vecs[i].wx1 >= 0) wall_map[vecs[i].wx1][vecs[i].wy1] = 1'b1;
            {key_up, key_down, key_left, key_right} = vecs[i].keys;
            ent_q = 0;
            ent_s = 0;
            cycle();
            {key_up, key_down, key_left, key_right} = 4'b0000;
            repeat (8 * vecs[i].ticks - 1) cycle();
            check({vecs[i].name, "_x"}, 32'(pac_x), vecs[i].ex);
            check({vecs[i].name, "_y"}, 32'(pac_y), vecs[i].ey);
            check({vecs[i].name, "_dir"}, 32'(pac_dir), vecs[i].edir);
            check({vecs[i].name, "_queries"}, 32'(ent_q), vecs[i].eq);
            check({vecs[i].name, "_steps"}, 32'(ent_s), vecs[i].es);
        end

        // gameover during the decision cycle: no move, keys ignored, resume later.
        clear_map();
        wait_phase();
        ent_q = 0;
        ent_s = 0;
        repeat (4) cycle();
        gameover = 1'b1;
        cycle();
        key_up = 1'b1;
        repeat (3) cycle();
        key_up = 1'b0;
        repeat (2) cycle();
        check("go_queries", 32'(ent_q), 1);
        check("go_steps", 32'(ent_s), 0);
        check("go_pac_x", 32'(pac_x), WRAP ? 23 : 0);
        check("go_pac_y", 32'(pac_y), WRAP ? 11 : 12);
        gameover = 1'b0;
        lat = -1;
        qx = -1;
        qy = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (wall_req === 1'b1 && lat < 0) begin
                lat = i + 1;
                qx = int'(wall_x);
                qy = int'(wall_y);
            end
        end
        check("resume_latency", 32'(lat), 8);
        check("resume_query_x", 32'(qx), WRAP ? 22 : 0);
        check("resume_query_y", 32'(qy), WRAP ? 11 : 13);

        // Randomized walls, keys, gameover and reset against the reference.
        for (int it = 0; it < 150; it++) begin
            wait_phase();
            for (int x = 0; x < 32; x++)
                for (int y = 0; y < 32; y++)
                    wall_map[x][y] = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 1) == 0)
                {key_up, key_down, key_left, key_right} = 4'($urandom_range(1, 15));
            cycle();
            {key_up, key_down, key_left, key_right} = 4'b0000;
            for (int k = 0; k < 7; k++) begin
                gameover = ($urandom_range(0, 19) == 0);
                reset_n  = ($urandom_range(0, 39) != 0);
                cycle();
            end
            gameover = 1'b0;
            reset_n  = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
